// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor.
// Exports: DEFAULT_WIDTH (operand width) and state_t (IDLE/RUN/DONE controller states).
package serial_sub_pkg;

    localparam int unsigned DEFAULT_WIDTH = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_sub1b.sv
// One-bit full subtractor, purely combinational.
// Ports: ai (minuend bit), bi (subtrahend bit), bin (borrow in),
//        d (difference bit), bout (borrow out).
module full_sub1b (
    input  logic ai,
    input  logic bi,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = ai ^ bi ^ bin;
    assign bout = (~ai & bi) | (~(ai ^ bi) & bin);

endmodule

// File: rtl/serial_sub6b.sv
// Bit-serial unsigned subtractor: diff = (a - b) mod 2^WIDTH, one bit per clock, LSB first.
// Ports: clk, rst (async active-high), start (request, ignored while busy),
//        a/b (operands, captured on accepted start), diff/borrow/zero (held results),
//        busy (operation in progress), done (one-cycle result-valid pulse).
module serial_sub6b
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_d;
    logic             load;
    logic             shift;
    logic             finish;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] diff_sr;
    logic             bor_int;
    logic [CW-1:0]    cnt;
    logic             bit_d;
    logic             bit_bout;

    // Single bit slice fed from the LSBs of the operand shift registers.
    full_sub1b u_fs (
        .ai   (a_sr[0]),
        .bi   (b_sr[0]),
        .bin  (bor_int),
        .d    (bit_d),
        .bout (bit_bout)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d = state;
        load    = 1'b0;
        shift   = 1'b0;
        finish  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                shift = 1'b1;
                if (cnt == LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                finish  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Shift registers, bit counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr    <= '0;
            b_sr    <= '0;
            diff_sr <= '0;
            bor_int <= 1'b0;
            cnt     <= '0;
            diff    <= '0;
            borrow  <= 1'b0;
            zero    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= finish;
            busy <= (state_d != IDLE);
            if (load) begin
                a_sr    <= a;
                b_sr    <= b;
                diff_sr <= '0;
                bor_int <= 1'b0;
                cnt     <= '0;
            end else if (shift) begin
                a_sr    <= a_sr >> 1;
                b_sr    <= b_sr >> 1;
                // New result bit enters at the MSB; after WIDTH shifts diff_sr is aligned.
                diff_sr <= WIDTH'({bit_d, diff_sr} >> 1);
                bor_int <= bit_bout;
                // Saturate on the last bit so the counter never wraps.
                if (cnt != LAST) begin
                    cnt <= cnt + CW'(1);
                end
            end
            if (finish) begin
                diff   <= diff_sr;
                borrow <= bor_int;
                zero   <= (diff_sr == '0);
            end
        end
    end

endmodule
